qspi_psram_responder: RTL and testbench
=======================================

// Module: qspi_psram_responder
// PURPOSE
//  Synthesizable QSPI PSRAM target. It answers the accelerator's PSRAM master port (sck / ce_n / d[3:0] / douten)
//  from an internal byte array, so layer weights and activations can be served on-chip or in FPGA bring-up without a
//  physical PSRAM. It decodes SPI-mode commands with quad address/data: 0xEB quad read, 0x38 quad write.
//  A backdoor port preloads and inspects the array from the host side.
// PARAMETERS
//  MEM_BYTES    4096  array size in bytes; power of two; address taken modulo MEM_BYTES
//  WAIT_CYCLES  6     dummy sck rising edges between address and first read nibble (0xEB only)
//  ADDR_BITS    $clog2(MEM_BYTES)  derived; index width into the array
// PORTS
//  clk          in   1          system clock; all logic on its rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  psram_sck    in   1          serial clock from master; asynchronous to clk, 2-flop synchronized
//  psram_ce_n   in   1          chip enable from master, active low; 2-flop synchronized
//  psram_d_in   in   4          data lines as driven by master
//  psram_d_out  out  4          data driven back to master during read data phase
//  psram_d_oe   out  4          per-line output enable (4'hF while driving read data, else 4'h0)
//  busy         out  1          1 while ce_n (synchronized) is low
//  bd_we        in   1          backdoor write strobe
//  bd_addr      in   ADDR_BITS  backdoor address
//  bd_wdata     in   8          backdoor write data
//  bd_rdata     out  8          backdoor read data, registered, valid 1 clk after bd_addr
// BEHAVIOUR
//  Reset: state=IDLE; psram_d_out=0, psram_d_oe=0, busy=0, bd_rdata=0; array contents not reset.
//  Timing requirement: sck high and low phases >= 4 clk each. Edge detect is on the synchronized sck (rise/fall
//  pulses 1 clk wide, 3 clk after the pin edge).
//  FSM: IDLE -> CMD -> ADDR -> {DUMMY -> RD | WR | IGNORE}.
//   IDLE   : on synchronized ce_n falling, clear shift/counters -> CMD.
//   CMD    : 8 sck rises, sample d_in[0] MSB first.
//            0xEB -> ADDR(read); 0x38 -> ADDR(write); any other value -> IGNORE.
//   ADDR   : 6 sck rises, sample d_in[3:0] as nibbles MSB first -> 24-bit address. Array index = addr[ADDR_BITS-1:0].
//            For read, go to DUMMY; if WAIT_CYCLES=0, go to RD directly.
//   DUMMY  : count WAIT_CYCLES sck rises, then -> RD. oe stays 0.
//   RD     : on each sck fall, drive the next nibble, high nibble first. oe=4'hF from the first fall in RD.
//            After a low nibble, index = index+1, wrapping MEM_BYTES-1 -> 0. Master samples on sck rise.
//   WR     : on each sck rise, sample a nibble, high first. After the 2nd nibble, write the byte to array[index],
//            then index+1 with the same wrap.
//   IGNORE : no drive, no write; wait for ce_n high.
//  ce_n high in any state -> IDLE next clk, oe=0 the same clk. A partial nibble/byte or command is discarded;
//  completed bytes remain written.
//  Backdoor: bd_we writes the array any time. If bd_we and a WR byte commit hit the same clk and the same index,
//  the protocol write wins. bd_rdata = array[bd_addr], registered.
//  Simultaneous sck edge and ce_n rise in the same clk: ce_n wins (edge ignored).
//  Reset mid-transaction: immediate IDLE, oe=0; array keeps its contents.
// TESTING
//  1 backdoor load array[0x100..0x103]=11,22,33,44; 0xEB addr 0x000100, 6 dummy, 8 nibbles
//    -> master reads 1,1,2,2,3,3,4,4; oe=F only in data phase.
//  2 0x38 addr 0x000200, data A5 3C; then backdoor read 0x200, 0x201 -> A5, 3C; 0x202 unchanged.
//  3 Wrap: 0xEB at addr MEM_BYTES-1 (0xFFF), 2 bytes -> array[0xFFF] then array[0x000]. 0x38 at 0xFFF behaves the same.
//  4 Command 0x9F -> IGNORE: oe never asserted, array unchanged, next 0xEB transaction served correctly.
//  5 ce_n raised after 3 nibbles of 0x38 at 0x300 (data 12 3x) -> array[0x300]=12, array[0x301] unchanged, oe=0, busy=0.
//  6 rst_n pulsed low during RD phase -> oe=0, d_out=0 within same clk; subsequent read returns preloaded data.

Source files
------------

// File: rtl/qspi_psram_responder.sv
// qspi_psram_responder
//   QSPI PSRAM target backed by an on-chip byte array. Decodes SPI-mode
//   commands with quad address/data: 0xEB quad read (with WAIT_CYCLES dummy
//   sck rises), 0x38 quad write. Any other command is ignored until ce_n rises.
//   A backdoor port loads and inspects the array from the host side.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   psram_sck      master serial clock (async to clk, synchronized here)
//   psram_ce_n     master chip enable, active low (synchronized here)
//   psram_d_in     data lines as driven by the master
//   psram_d_out    read nibble driven back to the master
//   psram_d_oe     4'hF while driving read data, else 4'h0
//   busy           synchronized ce_n is low
//   bd_we/bd_addr/bd_wdata  backdoor write port
//   bd_rdata       array[bd_addr], registered (valid one clk after bd_addr)
//   state_dbg      current FSM state, for observation only
//
// Handshake: there is no valid/ready pair here. The master owns timing; sck
// high and low phases must each last at least 4 clk so that the synchronized
// edge pulse lands while the pin data is still stable.
module qspi_psram_responder #(
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_CYCLES = 6,
    parameter int ADDR_BITS   = $clog2(MEM_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 psram_sck,
    input  logic                 psram_ce_n,
    input  logic [3:0]           psram_d_in,
    output logic [3:0]           psram_d_out,
    output logic [3:0]           psram_d_oe,
    output logic                 busy,
    input  logic                 bd_we,
    input  logic [ADDR_BITS-1:0] bd_addr,
    input  logic [7:0]           bd_wdata,
    output logic [7:0]           bd_rdata,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]           mem [MEM_BYTES];
    logic [2:0]           sck_sync;
    logic [1:0]           ce_sync;
    logic                 ce_prev;
    logic                 ce_n_s, ce_fall, sck_rise, sck_fall;
    logic [15:0]          bit_cnt;
    logic [6:0]           cmd_sh;
    logic [7:0]           cmd_word;
    logic [ADDR_BITS-5:0] addr_sh;
    logic [ADDR_BITS-1:0] addr_word;
    logic [ADDR_BITS-1:0] idx;
    logic                 is_read;
    logic                 nib_lo;      // next nibble is the low half of the byte
    logic [3:0]           wr_hi;
    logic [3:0]           d_out_q;
    logic                 oe_q;
    logic                 wr_commit;

    // Synchronizers. sck_sync[2] is the previous synchronized value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= 3'b000;
            ce_sync  <= 2'b11;
            ce_prev  <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[1:0], psram_sck};
            ce_sync  <= {ce_sync[0], psram_ce_n};
            ce_prev  <= ce_sync[1];
        end
    end

    assign ce_n_s   = ce_sync[1];
    assign ce_fall  = ce_prev & ~ce_n_s;
    // A rising ce_n suppresses any sck edge seen in the same clk.
    assign sck_rise = sck_sync[1] & ~sck_sync[2] & ~ce_n_s;
    assign sck_fall = ~sck_sync[1] & sck_sync[2] & ~ce_n_s;

    // Shifting drops address bits above ADDR_BITS, which gives the modulo indexing.
    assign cmd_word  = {cmd_sh, psram_d_in[0]};
    assign addr_word = {addr_sh, psram_d_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        wr_commit = 1'b0;
        case (state_q)
            S_IDLE:  if (ce_fall) state_d = S_CMD;
            S_CMD:   if (sck_rise && bit_cnt == 16'd7)
                         state_d = (cmd_word == 8'hEB || cmd_word == 8'h38) ? S_ADDR : S_IGNORE;
            S_ADDR:  if (sck_rise && bit_cnt == 16'd5)
                         state_d = !is_read ? S_WR : (WAIT_CYCLES == 0) ? S_RD : S_DUMMY;
            S_DUMMY: if (sck_rise && bit_cnt == 16'(WAIT_CYCLES - 1)) state_d = S_RD;
            S_WR:    wr_commit = sck_rise & nib_lo;
            default: state_d = state_q;
        endcase
        if (state_q != S_IDLE && ce_n_s) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            cmd_sh  <= '0;
            addr_sh <= '0;
            idx     <= '0;
            is_read <= 1'b0;
            nib_lo  <= 1'b0;
            wr_hi   <= '0;
            d_out_q <= '0;
            oe_q    <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                bit_cnt <= '0;
                nib_lo  <= 1'b0;
            end else if (sck_rise) begin
                bit_cnt <= bit_cnt + 16'd1;
            end
            if (state_d != S_RD) oe_q <= 1'b0;
            case (state_q)
                S_CMD: if (sck_rise) begin
                    cmd_sh <= cmd_word[6:0];
                    if (bit_cnt == 16'd7) is_read <= (cmd_word == 8'hEB);
                end
                S_ADDR: if (sck_rise) begin
                    addr_sh <= addr_word[ADDR_BITS-5:0];
                    if (bit_cnt == 16'd5) idx <= addr_word;
                end
                S_RD: if (sck_fall && state_d == S_RD) begin
                    d_out_q <= nib_lo ? mem[idx][3:0] : mem[idx][7:4];
                    oe_q    <= 1'b1;
                    nib_lo  <= ~nib_lo;
                    if (nib_lo) idx <= idx + 1'b1;
                end
                S_WR: if (sck_rise) begin
                    if (!nib_lo) wr_hi <= psram_d_in;
                    nib_lo <= ~nib_lo;
                    if (nib_lo) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Array is deliberately not reset. The protocol write comes second so it
    // wins when both ports target the same index in the same clk.
    always_ff @(posedge clk) begin
        if (bd_we)     mem[bd_addr] <= bd_wdata;
        if (wr_commit) mem[idx]     <= {wr_hi, psram_d_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bd_rdata <= '0;
        else        bd_rdata <= mem[bd_addr];
    end

    // Output enable drops in the same clk the synchronized ce_n goes high.
    assign psram_d_oe  = (oe_q && !ce_n_s) ? 4'hF : 4'h0;
    assign psram_d_out = d_out_q;
    assign busy        = ~ce_n_s;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_qspi_psram_responder.sv
module tb_qspi_psram_responder;
    localparam int MEM   = 4096;
    localparam int AB    = 12;
    localparam int WAITC = 6;
    localparam int HALF  = 8;   // clk per sck phase

    logic          clk = 1'b0;
    logic          rst_n;
    logic          psram_sck, psram_ce_n;
    logic [3:0]    psram_d_in, psram_d_out, psram_d_oe;
    logic          busy, bd_we;
    logic [AB-1:0] bd_addr;
    logic [7:0]    bd_wdata, bd_rdata;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [MEM];
    logic [3:0] exp_q [$];

    typedef struct {
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t vecs [4];

    qspi_psram_responder #(.MEM_BYTES(MEM), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst_n(rst_n), .psram_sck(psram_sck), .psram_ce_n(psram_ce_n),
        .psram_d_in(psram_d_in), .psram_d_out(psram_d_out), .psram_d_oe(psram_d_oe),
        .busy(busy), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [AB-1:0] a, input logic [7:0] v);
        bd_we = 1'b1; bd_addr = a; bd_wdata = v;
        wait_clk(1);
        bd_we = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic bd_check(input logic [AB-1:0] a, input logic [7:0] v, input string name);
        bd_addr = a;
        wait_clk(1);
        chk(name, {24'h0, bd_rdata}, {24'h0, v});
    endtask

    task automatic pulse(input logic [3:0] d);
        psram_d_in = d;
        wait_clk(HALF);
        psram_sck = 1'b1;
        wait_clk(HALF);
        psram_sck = 1'b0;
    endtask

    task automatic start_tx();
        psram_ce_n = 1'b0;
        wait_clk(HALF);
        chk("busy_on", {31'h0, busy}, 32'h1);
    endtask

    task automatic end_tx();
        psram_ce_n = 1'b1;
        wait_clk(HALF);
        chk("oe_after_ce", {28'h0, psram_d_oe}, 32'h0);
        chk("busy_off", {31'h0, busy}, 32'h0);
    endtask

    task automatic header(input logic [7:0] cmd, input logic [23:0] addr);
        for (int i = 7; i >= 0; i--) pulse({3'b000, cmd[i]});
        if (cmd == 8'hEB || cmd == 8'h38)
            for (int n = 5; n >= 0; n--) pulse(addr[n*4 +: 4]);
    endtask

    task automatic read_nibble(input string name);
        logic [3:0] e;
        wait_clk(HALF);
        e = exp_q.pop_front();
        chk({name, "_d"}, {28'h0, psram_d_out}, {28'h0, e});
        chk({name, "_oe"}, {28'h0, psram_d_oe}, 32'hF);
        psram_sck = 1'b1;
        wait_clk(HALF);
        psram_sck = 1'b0;
    endtask

    task automatic read_tx(input logic [23:0] addr, input int n, input logic [31:0] exp, input string name);
        start_tx();
        header(8'hEB, addr);
        for (int i = 0; i < WAITC; i++) begin
            chk({name, "_dummy_oe"}, {28'h0, psram_d_oe}, 32'h0);
            pulse(4'h0);
        end
        for (int j = 0; j < 2 * n; j++) exp_q.push_back(exp[31 - 4*j -: 4]);
        for (int j = 0; j < 2 * n; j++) read_nibble(name);
        end_tx();
    endtask

    // Sends nnib data nibbles; only whole bytes land in the model.
    task automatic write_tx(input logic [23:0] addr, input int nnib, input logic [31:0] data);
        start_tx();
        header(8'h38, addr);
        for (int j = 0; j < nnib; j++) pulse(data[31 - 4*j -: 4]);
        end_tx();
        for (int k = 0; k < nnib / 2; k++)
            ref_mem[(int'(addr) + k) % MEM] = data[31 - 8*k -: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [23:0] addr, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[31 - 8*k -: 8] = ref_mem[(int'(addr) + k) % MEM];
        return r;
    endfunction

    initial begin
        psram_sck = 1'b0; psram_ce_n = 1'b1; psram_d_in = '0;
        bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
        rst_n = 1'b0;
        wait_clk(3);
        chk("rst_oe", {28'h0, psram_d_oe}, 32'h0);
        chk("rst_dout", {28'h0, psram_d_out}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_bd_rdata", {24'h0, bd_rdata}, 32'h0);
        rst_n = 1'b1;
        wait_clk(2);

        for (int i = 0; i < MEM; i++) bd_write(AB'(i), 8'($urandom));

        // Directed reads, including wrap and high address bits being dropped.
        bd_write(12'h100, 8'h11); bd_write(12'h101, 8'h22);
        bd_write(12'h102, 8'h33); bd_write(12'h103, 8'h44);
        bd_write(12'hFFF, 8'h5A); bd_write(12'h000, 8'hC3);
        vecs[0] = '{24'h000100, 4, 32'h11223344};
        vecs[1] = '{24'h000FFF, 2, 32'h5AC30000};
        vecs[2] = '{24'h7F0FFF, 2, 32'h5AC30000};
        vecs[3] = '{24'h000101, 2, 32'h22330000};
        for (int v = 0; v < 4; v++) read_tx(vecs[v].addr, vecs[v].nbytes, vecs[v].exp, $sformatf("vec%0d", v));

        // Write then backdoor readback.
        bd_write(12'h202, 8'h77);
        write_tx(24'h000200, 4, 32'hA53C0000);
        bd_check(12'h200, 8'hA5, "wr_200");
        bd_check(12'h201, 8'h3C, "wr_201");
        bd_check(12'h202, 8'h77, "wr_202_keep");

        // Write wrapping past the top of the array.
        write_tx(24'h000FFF, 4, 32'h96690000);
        bd_check(12'hFFF, 8'h96, "wrwrap_fff");
        bd_check(12'h000, 8'h69, "wrwrap_000");

        // Unknown command: no drive, no write, next read still fine.
        start_tx();
        header(8'h9F, 24'h0);
        for (int i = 0; i < 6; i++) begin
            pulse(4'hF);
            chk("ign_oe", {28'h0, psram_d_oe}, 32'h0);
        end
        end_tx();
        bd_check(12'h100, 8'h11, "ign_keep");
        read_tx(vecs[0].addr, vecs[0].nbytes, vecs[0].exp, "after_ign");

        // Abort after three data nibbles: first byte kept, partial byte dropped.
        bd_write(12'h300, 8'h00); bd_write(12'h301, 8'hEE);
        write_tx(24'h000300, 3, 32'h12300000);
        bd_check(12'h300, 8'h12, "abort_300");
        bd_check(12'h301, 8'hEE, "abort_301");

        // Reset in the read data phase.
        start_tx();
        header(8'hEB, 24'h000100);
        for (int i = 0; i < WAITC; i++) pulse(4'h0);
        exp_q.push_back(4'h1); exp_q.push_back(4'h1); exp_q.push_back(4'h2);
        for (int j = 0; j < 3; j++) read_nibble("prerst");
        wait_clk(HALF);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe", {28'h0, psram_d_oe}, 32'h0);
        chk("rst_mid_dout", {28'h0, psram_d_out}, 32'h0);
        psram_ce_n = 1'b1;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(HALF);
        read_tx(vecs[0].addr, vecs[0].nbytes, vecs[0].exp, "after_rst");

        // Randomized traffic against the array model.
        for (int t = 0; t < 20; t++) begin
            int op, n;
            logic [23:0] addr;
            logic [31:0] data;
            logic [7:0] cmd;
            op   = $urandom_range(0, 3);
            addr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) addr[11:0] = 12'hFFD + 12'($urandom_range(0, 2));
            if (op <= 1) begin
                n = $urandom_range(1, 4);
                read_tx(addr, n, model_read(addr, n), "rnd_rd");
            end else if (op == 2) begin
                n    = $urandom_range(1, 3);
                data = $urandom;
                write_tx(addr, 2 * n, data);
                bd_check(addr[11:0], ref_mem[addr[11:0]], "rnd_wr_first");
                bd_check(12'(int'(addr[11:0]) + n - 1), ref_mem[(int'(addr[11:0]) + n - 1) % MEM], "rnd_wr_last");
            end else begin
                do cmd = 8'($urandom); while (cmd == 8'hEB || cmd == 8'h38);
                start_tx();
                header(cmd, 24'h0);
                for (int i = 0; i < 4; i++) begin
                    pulse(4'($urandom));
                    chk("rnd_ign_oe", {28'h0, psram_d_oe}, 32'h0);
                end
                end_tx();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end
endmodule
